// File: rtl/pbus_master.sv
// pbus_master: single-outstanding initiator for the peripheral memory bus.
// Accepts one CPU request at a time and drives it onto the bus with registered
// signals. It returns a one-cycle response pulse and keeps bus_valid low for at
// least two cycles between transactions.
// Optional feature macro: PBUS_TIMEOUT_EN. When it is defined, an access that
// sees no bus_ready for TIMEOUT_CYCLES cycles is aborted with an error
// response. Without the macro, ACCESS waits forever and resp_err is tied to 0.
module pbus_master #(
    parameter int unsigned ADDR_W         = 24,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic              bus_valid_q,  bus_valid_d;
    logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
    logic              bus_write_q,  bus_write_d;
    logic [31:0]       bus_wdata_q,  bus_wdata_d;
    logic [3:0]        bus_wstrb_q,  bus_wstrb_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

`ifdef PBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q, resp_err_d;
`else
    // Timeout parameters have no function in this build.
    logic unused_params;
    assign unused_params = ^{ERR_RDATA, 32'(TIMEOUT_CYCLES)};
`endif

    // Request port is ready only while idle; it never looks at req_valid.
    assign req_ready  = (state_q == IDLE);

    assign bus_valid  = bus_valid_q;
    assign bus_addr   = bus_addr_q;
    assign bus_write  = bus_write_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
`ifdef PBUS_TIMEOUT_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

    // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        // NOTE: every *_d gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_write_d  = bus_write_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
`ifdef PBUS_TIMEOUT_EN
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bus_addr_d  = req_addr;
                    bus_write_d = req_write;
                    bus_wdata_d = req_wdata;
                    bus_wstrb_d = req_write ? req_wstrb : 4'h0;
                    bus_valid_d = 1'b1;
                    state_d     = ACCESS;
`ifdef PBUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ACCESS: begin
                // A completion wins over a timeout that expires in the same cycle.
                if (bus_ready) begin
                    resp_rdata_d = bus_write_q ? 32'h0 : bus_rdata;
                    resp_valid_d = 1'b1;
                    bus_valid_d  = 1'b0;
                    state_d      = RESP;
`ifdef PBUS_TIMEOUT_EN
                    resp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    resp_rdata_d = ERR_RDATA;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    bus_valid_d  = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge sys_clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_write_q  <= 1'b0;
            bus_wdata_q  <= 32'h0;
            bus_wstrb_q  <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
`ifdef PBUS_TIMEOUT_EN
            cnt_q        <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_write_q  <= bus_write_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef PBUS_TIMEOUT_EN
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_pbus_master.sv
// Self-checking bench for pbus_master. Runs with or without PBUS_TIMEOUT_EN.
// Expected responses come from a transaction-level model: the access length is
// the ready cycle, or TIMEOUT_CYCLES when the access is aborted. The latency is
// the access length plus one.
`timescale 1ns/1ps
module tb_pbus_master;

    localparam int          ADDR_W = 24;
    localparam int          TO     = 8;
    localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
`ifdef PBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              sys_clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_write = 1'b0;
    logic [31:0]       req_wdata = 32'h0;
    logic [3:0]        req_wstrb = 4'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_write;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_rdata = 32'h0;
    logic              bus_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    pbus_master #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus_valid  (bus_valid),
        .bus_addr   (bus_addr),
        .bus_write  (bus_write),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready)
    );

    // Transaction model. ready_at is the 1-based ACCESS cycle where the
    // responder answers, and 0 means it never answers.
    function automatic void model(input bit wr, input int ready_at, input logic [31:0] rd,
                                  output int access, output logic [31:0] data, output logic err);
        if (ready_at >= 1 && (!TO_EN || ready_at <= TO)) begin
            access = ready_at;
            err    = 1'b0;
            data   = wr ? 32'h0 : rd;
        end else begin
            access = TO;
            err    = 1'b1;
            data   = ERR;
        end
    endfunction

    task automatic do_txn(input string name, input logic [ADDR_W-1:0] addr, input bit wr,
                          input logic [31:0] wd, input logic [3:0] ws, input int ready_at,
                          input logic [31:0] rd);
        int          access;
        int          k;
        int          lat;
        int          vcyc;
        int          bound;
        bit          stable_ok;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [3:0]  exp_ws;
        logic [31:0] got_data;
        logic        got_err;
        model(wr, ready_at, rd, access, exp_data, exp_err);
        exp_ws = wr ? ws : 4'h0;

        // Request cycle (IDLE). A random bus_ready here must be ignored.
        @(negedge sys_clk);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws;
        bus_ready = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL %s req_ready_idle got=%b exp=1", name, req_ready);
        end

        // Change the request fields after acceptance; the bus outputs must stay registered.
        @(negedge sys_clk);
        req_valid = 1'b0; req_addr = ADDR_W'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
        req_write = ~wr;
        lat = 0; vcyc = 0; stable_ok = 1'b1; k = 1;
        got_data = 32'h0; got_err = 1'b0;
        bound = ready_at + TO + 20;
        while (k <= bound && lat == 0) begin
            if (k > 1) @(negedge sys_clk);
            if (resp_valid === 1'b1) begin
                lat = k; got_data = resp_rdata; got_err = resp_err;
                checks++;
                if (bus_valid !== 1'b0 || req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s resp_cycle_bus bus_valid=%b req_ready=%b exp 0/0", name, bus_valid, req_ready);
                end
            end
            if (bus_valid === 1'b1) begin
                vcyc++;
                if (bus_addr !== addr || bus_write !== wr || bus_wdata !== wd || bus_wstrb !== exp_ws)
                    stable_ok = 1'b0;
            end
            if (k <= access && lat == 0) begin
                bus_ready = (k == ready_at);
                bus_rdata = (k == ready_at) ? rd : $urandom;
            end else begin
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
            k++;
        end
        bus_ready = 1'b0;

        checks++;
        if (lat == 0) begin
            failures++; $display("FAIL %s no_response within %0d cycles", name, bound);
            return;
        end
        if (lat != access + 1) begin
            failures++; $display("FAIL %s latency got=%0d exp=%0d cycles after accept", name, lat, access + 1);
        end
        checks++;
        if (vcyc != access) begin
            failures++; $display("FAIL %s bus_valid_cycles got=%0d exp=%0d", name, vcyc, access);
        end
        checks++;
        if (!stable_ok) begin
            failures++;
            $display("FAIL %s bus_fields last addr=%h wr=%b wd=%h ws=%h exp addr=%h wr=%b wd=%h ws=%h",
                     name, bus_addr, bus_write, bus_wdata, bus_wstrb, addr, wr, wd, exp_ws);
        end
        checks++;
        if (got_data !== exp_data) begin
            failures++; $display("FAIL %s resp_rdata got=%h exp=%h", name, got_data, exp_data);
        end
        checks++;
        if (got_err !== exp_err) begin
            failures++; $display("FAIL %s resp_err got=%b exp=%b", name, got_err, exp_err);
        end

        // The cycle after the pulse: back to IDLE, and the response data is held.
        @(negedge sys_clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_data || resp_err !== exp_err) begin
            failures++;
            $display("FAIL %s after_resp resp_valid=%b req_ready=%b rdata=%h err=%b exp 0/1/%h/%b",
                     name, resp_valid, req_ready, resp_rdata, resp_err, exp_data, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if (bus_valid !== 1'b0 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset valids bus_valid=%b resp_valid=%b exp 0/0", bus_valid, resp_valid);
        end
        checks++;
        if (bus_addr !== '0 || bus_write !== 1'b0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset bus_regs addr=%h wr=%b wd=%h ws=%h exp all 0", bus_addr, bus_write, bus_wdata, bus_wstrb);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            failures++; $display("FAIL reset resp_regs rdata=%h err=%b exp 0/0", resp_rdata, resp_err);
        end
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic test_read();
        do_txn("read", 24'h000040, 1'b0, 32'h0, 4'hF, 2, 32'h0000_0003);
    endtask

    task automatic test_write();
        do_txn("write", 24'h000100, 1'b1, 32'h0000_000A, 4'hF, 1, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] q[$];
        logic [ADDR_W-1:0] exp_a;
        int  gap;
        int  rises;
        int  resps;
        bit  prev_bv;
        bit  accept_now;
        bit  gap_ok;
        bit  ready_ok;
        bit  addr_ok;
        gap = 0; rises = 0; resps = 0; prev_bv = 1'b0;
        gap_ok = 1'b1; ready_ok = 1'b1; addr_ok = 1'b1;
        @(negedge sys_clk);
        req_valid = 1'b1; req_write = 1'b0; req_wstrb = 4'hF; req_addr = ADDR_W'($urandom);
        bus_ready = 1'b1; bus_rdata = $urandom;
        for (int c = 0; c < 30; c++) begin
            if (bus_valid === 1'b1) begin
                if (!prev_bv) begin
                    if (rises > 0 && gap < 2) gap_ok = 1'b0;
                    rises++;
                    if (q.size() == 0) addr_ok = 1'b0;
                    else begin
                        exp_a = q.pop_front();
                        if (bus_addr !== exp_a) addr_ok = 1'b0;
                    end
                end
                gap = 0;
            end else begin
                gap++;
            end
            if (resp_valid === 1'b1) resps++;
            accept_now = (req_ready === 1'b1);
            if (accept_now) begin
                if (bus_valid !== 1'b0 || resp_valid !== 1'b0) ready_ok = 1'b0;
                q.push_back(req_addr);
            end
            prev_bv = (bus_valid === 1'b1);
            @(negedge sys_clk);
            if (accept_now) req_addr = ADDR_W'($urandom);
            bus_rdata = $urandom;
        end
        req_valid = 1'b0;
        bus_ready = 1'b0;
        checks++;
        if (rises != 10) begin
            failures++; $display("FAIL b2b transactions got=%0d exp=10", rises);
        end
        checks++;
        if (resps != 10) begin
            failures++; $display("FAIL b2b responses got=%0d exp=10", resps);
        end
        checks++;
        if (!gap_ok) begin
            failures++; $display("FAIL b2b idle_gap got=<2 exp>=2");
        end
        checks++;
        if (!ready_ok) begin
            failures++; $display("FAIL b2b accept_outside_idle got=1 exp=0");
        end
        checks++;
        if (!addr_ok) begin
            failures++; $display("FAIL b2b bus_addr_order got=wrong exp=accepted order");
        end
        @(negedge sys_clk);
    endtask

    task automatic test_timeout();
`ifdef PBUS_TIMEOUT_EN
        do_txn("timeout", 24'h0000A0, 1'b0, 32'h0, 4'h0, 0, 32'h5555_5555);
        do_txn("ready_wins", 24'h0000A4, 1'b0, 32'h0, 4'h0, TO, 32'h0000_0077);
        do_txn("timeout_wr", 24'h0000A8, 1'b1, 32'hCAFE_0001, 4'h3, 0, 32'h0);
`else
        do_txn("no_timeout", 24'h0000A0, 1'b0, 32'h0, 4'h0, 300, 32'h0000_0077);
`endif
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        seen = 1'b0;
        @(negedge sys_clk);
        req_valid = 1'b1; req_addr = 24'h0000C0; req_write = 1'b0; bus_ready = 1'b0;
        @(negedge sys_clk);
        req_valid = 1'b0;
        checks++;
        if (bus_valid !== 1'b1) begin
            failures++; $display("FAIL rst_mid access1 bus_valid got=%b exp=1", bus_valid);
        end
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || bus_addr !== '0) begin
            failures++; $display("FAIL rst_mid async_drop bus_valid=%b bus_addr=%h exp 0/0", bus_valid, bus_addr);
        end
        repeat (3) begin
            @(negedge sys_clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        rst = 1'b0;
        bus_ready = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        bus_ready = 1'b0;
        checks++;
        if (seen) begin
            failures++; $display("FAIL rst_mid lost_response resp_valid got=1 exp=0");
        end
        do_txn("after_rst", 24'h0000C4, 1'b0, 32'h0, 4'h0, 1, 32'h0BAD_F00D);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_txn("rand", ADDR_W'($urandom), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                   TO_EN ? int'($urandom_range(0, 10)) : int'($urandom_range(1, 6)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
